// File: rtl/mem_lsu_if.sv
// Data-bus bundle between the memory-access stage and the data memory/bus.
interface mem_lsu_if;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_sel;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;

    modport master (output d_req, d_we, d_addr, d_sel, d_wdata,
                    input  d_rdata, d_ack);
    modport slave  (input  d_req, d_we, d_addr, d_sel, d_wdata,
                    output d_rdata, d_ack);
endinterface

// File: rtl/mem_lsu.sv
// MIPS memory-access stage: passes ALU results through, runs a req/ack bus
// transaction for loads/stores with big-endian lane selection and a timeout.
module mem_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic        flush,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq,
    output logic        addr_err,
    output logic        bus_err,
    mem_lsu_if.master   dbus
);
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]  state_q, state_d;
    logic        req_q, we_q, kill_q, err_q, wreg_q;
    logic [3:0]  sel_q;
    logic [31:0] addr_q, wdat_q, rdata_q;
    logic [4:0]  wd_q;
    logic [7:0]  op_q;
    logic [1:0]  off_q;
    logic [CW-1:0] cnt_q;

    logic is_byte, is_half, is_word, is_store, is_mem, misal, start, to_hit;
    logic [3:0]  sel_c;
    logic [31:0] wdat_c, load_v;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign is_byte  = (aluop_i == EXE_LB_OP) || (aluop_i == EXE_LBU_OP) || (aluop_i == EXE_SB_OP);
    assign is_half  = (aluop_i == EXE_LH_OP) || (aluop_i == EXE_LHU_OP) || (aluop_i == EXE_SH_OP);
    assign is_word  = (aluop_i == EXE_LW_OP) || (aluop_i == EXE_SW_OP);
    assign is_store = (aluop_i == EXE_SB_OP) || (aluop_i == EXE_SH_OP) || (aluop_i == EXE_SW_OP);
    assign is_mem   = is_byte || is_half || is_word;
    assign misal    = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
    assign start    = (state_q == S_IDLE) && is_mem && !misal && !flush;
    assign to_hit   = (cnt_q == CW'(TIMEOUT - 1));

    // Big-endian lanes: byte offset 0 lives in bits [31:24].
    always_comb begin
        sel_c  = 4'b1111;
        wdat_c = reg2_i;
        if (is_byte) begin
            sel_c  = 4'b1000 >> mem_addr_i[1:0];
            wdat_c = {4{reg2_i[7:0]}};
        end else if (is_half) begin
            sel_c  = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            wdat_c = {2{reg2_i[15:0]}};
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    byte_v = rdata_q[31:24];
            2'd1:    byte_v = rdata_q[23:16];
            2'd2:    byte_v = rdata_q[15:8];
            default: byte_v = rdata_q[7:0];
        endcase
        half_v = off_q[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (op_q)
            EXE_LB_OP:  load_v = {{24{byte_v[7]}}, byte_v};
            EXE_LBU_OP: load_v = {24'h0, byte_v};
            EXE_LH_OP:  load_v = {{16{half_v[15]}}, half_v};
            EXE_LHU_OP: load_v = {16'h0, half_v};
            default:    load_v = rdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_BUS;
            S_BUS:   if (dbus.d_ack || to_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wd_o     = wd_i;
        wreg_o   = wreg_i;
        wdata_o  = wdata_i;
        stallreq = 1'b0;
        addr_err = 1'b0;
        bus_err  = 1'b0;
        case (state_q)
            S_IDLE: if (is_mem) begin
                wreg_o   = 1'b0;
                addr_err = misal && !flush;
                stallreq = start;
            end
            S_BUS: begin
                wd_o     = wd_q;
                wreg_o   = 1'b0;
                stallreq = 1'b1;
            end
            S_DONE: begin
                wd_o    = wd_q;
                wdata_o = load_v;
                wreg_o  = wreg_q && !err_q && !kill_q && !flush;
                bus_err = err_q;
            end
            default: ;
        endcase
        // Reset must release the pipeline and block writeback without a clock.
        if (!rst) begin
            stallreq = 1'b0;
            wreg_o   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            addr_q  <= 32'h0;
            wdat_q  <= 32'h0;
            rdata_q <= 32'h0;
            wd_q    <= 5'h0;
            wreg_q  <= 1'b0;
            op_q    <= 8'h0;
            off_q   <= 2'b00;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (start) begin
                    req_q  <= 1'b1;
                    we_q   <= is_store;
                    sel_q  <= sel_c;
                    addr_q <= {mem_addr_i[31:2], 2'b00};
                    wdat_q <= wdat_c;
                    wd_q   <= wd_i;
                    wreg_q <= wreg_i && !is_store;
                    op_q   <= aluop_i;
                    off_q  <= mem_addr_i[1:0];
                    cnt_q  <= '0;
                    kill_q <= 1'b0;
                    err_q  <= 1'b0;
                end
                S_BUS: begin
                    cnt_q  <= cnt_q + 1'b1;
                    kill_q <= kill_q || flush;
                    if (dbus.d_ack) begin
                        rdata_q <= dbus.d_rdata;
                        req_q   <= 1'b0;
                    end else if (to_hit) begin
                        err_q <= 1'b1;
                        req_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    cnt_q  <= '0;
                    kill_q <= 1'b0;
                    err_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign dbus.d_req   = req_q;
    assign dbus.d_we    = we_q;
    assign dbus.d_addr  = addr_q;
    assign dbus.d_sel   = sel_q;
    assign dbus.d_wdata = wdat_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: pass-through, loads/stores, alignment, timeout, flush, reset.
module tb_mem_lsu;
    localparam logic [7:0] ADD_OP = 8'b0010_0000;
    localparam logic [7:0] LB_OP  = 8'b1110_0000;
    localparam logic [7:0] LH_OP  = 8'b1110_0001;
    localparam logic [7:0] LW_OP  = 8'b1110_0011;
    localparam logic [7:0] LBU_OP = 8'b1110_0100;
    localparam logic [7:0] SH_OP  = 8'b1110_1001;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic        flush;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq;
    logic        addr_err;
    logic        bus_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_lsu_if bus ();

    mem_lsu #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .flush(flush),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq(stallreq),
        .addr_err(addr_err), .bus_err(bus_err), .dbus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one memory op until stallreq drops; bus responds after 'waits'
    // unacked request cycles (waits<0: never), flush pulses in request cycle flush_at.
    task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                          input logic [31:0] rd, input int waits, input int flush_at,
                          output int stalls, output int reqs, output logic [3:0] sel,
                          output logic we, output logic [31:0] wdat, output logic [31:0] ad,
                          output logic stable);
        stalls = 0; reqs = 0; sel = 4'h0; we = 1'b0; wdat = 32'h0; ad = 32'h0; stable = 1'b1;
        aluop_i = op; mem_addr_i = addr; reg2_i = r2; wd_i = 5'd5; wreg_i = 1'b1;
        #1;
        while (stallreq && stalls < 40) begin
            stalls++;
            if (bus.d_req) begin
                reqs++;
                if (reqs == 1) begin
                    sel = bus.d_sel; we = bus.d_we; wdat = bus.d_wdata; ad = bus.d_addr;
                end else if (sel !== bus.d_sel || we !== bus.d_we || wdat !== bus.d_wdata || ad !== bus.d_addr) begin
                    stable = 1'b0;
                end
                bus.d_ack   = (waits >= 0) && (reqs > waits);
                bus.d_rdata = bus.d_ack ? rd : 32'hDEAD_BEEF;
                flush       = (reqs == flush_at);
            end
            @(posedge clk); #1;
            bus.d_ack = 1'b0; flush = 1'b0;
        end
        #1;
        chk("stall_bound", 32'(stalls < 40), 32'd1);
    endtask

    task automatic gap();
        aluop_i = ADD_OP; wreg_i = 1'b1; wd_i = 5'd9;
        @(posedge clk); #1;
    endtask

    int          st, rq;
    logic [3:0]  sl;
    logic        w, stb;
    logic [31:0] wdv, adv;

    initial begin
        rst = 1'b0; aluop_i = ADD_OP; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h0;
        mem_addr_i = 32'h0; reg2_i = 32'h0; flush = 1'b0;
        bus.d_ack = 1'b0; bus.d_rdata = 32'h0;
        #3;
        chk("rst_stall", 32'(stallreq), 32'd0);
        chk("rst_wreg",  32'(wreg_o),   32'd0);
        chk("rst_req",   32'(bus.d_req), 32'd0);
        chk("rst_sel",   32'(bus.d_sel), 32'd0);
        chk("rst_addr",  bus.d_addr,     32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // pass-through
        aluop_i = ADD_OP; wd_i = 5'd3; wdata_i = 32'h1234_5678; #1;
        chk("add_wd",    32'(wd_o),     32'd3);
        chk("add_wdata", wdata_o,       32'h1234_5678);
        chk("add_wreg",  32'(wreg_o),   32'd1);
        chk("add_stall", 32'(stallreq), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("add_noreq", 32'(bus.d_req), 32'd0);
        end

        // LB with two wait cycles
        do_mem(LB_OP, 32'h0000_1001, 32'h0, 32'h11F2_3344, 2, -1, st, rq, sl, w, wdv, adv, stb);
        chk("lb_stalls", 32'(st), 32'd4);
        chk("lb_reqs",   32'(rq), 32'd3);
        chk("lb_sel",    32'(sl), 32'b0100);
        chk("lb_we",     32'(w),  32'd0);
        chk("lb_addr",   adv,     32'h0000_1000);
        chk("lb_stable", 32'(stb), 32'd1);
        chk("lb_data",   wdata_o, 32'hFFFF_FFF2);
        chk("lb_wreg",   32'(wreg_o), 32'd1);
        chk("lb_wd",     32'(wd_o),   32'd5);
        gap();

        do_mem(LBU_OP, 32'h0000_1001, 32'h0, 32'h11F2_3344, 2, -1, st, rq, sl, w, wdv, adv, stb);
        chk("lbu_data",  wdata_o, 32'h0000_00F2);
        chk("lbu_wreg",  32'(wreg_o), 32'd1);
        gap();

        do_mem(LH_OP, 32'h0000_1002, 32'h0, 32'h1122_F344, 0, -1, st, rq, sl, w, wdv, adv, stb);
        chk("lh_sel",    32'(sl), 32'b0011);
        chk("lh_data",   wdata_o, 32'hFFFF_F344);
        gap();

        // SH with immediate ack
        do_mem(SH_OP, 32'h0000_2002, 32'hAAAA_BEEF, 32'h0, 0, -1, st, rq, sl, w, wdv, adv, stb);
        chk("sh_stalls", 32'(st), 32'd2);
        chk("sh_we",     32'(w),  32'd1);
        chk("sh_sel",    32'(sl), 32'b0011);
        chk("sh_wdata",  wdv,     32'hBEEF_BEEF);
        chk("sh_wreg",   32'(wreg_o), 32'd0);
        gap();

        // misaligned LW
        aluop_i = LW_OP; mem_addr_i = 32'h0000_3002; wreg_i = 1'b1; #1;
        chk("mis_aerr",  32'(addr_err), 32'd1);
        chk("mis_wreg",  32'(wreg_o),   32'd0);
        chk("mis_stall", 32'(stallreq), 32'd0);
        @(posedge clk); #1;
        chk("mis_noreq", 32'(bus.d_req), 32'd0);
        gap();

        // timeout
        do_mem(LW_OP, 32'h0000_3000, 32'h0, 32'h0, -1, -1, st, rq, sl, w, wdv, adv, stb);
        chk("to_reqs",   32'(rq), 32'd16);
        chk("to_stalls", 32'(st), 32'd17);
        chk("to_berr",   32'(bus_err), 32'd1);
        chk("to_wreg",   32'(wreg_o),  32'd0);
        gap();
        chk("to_berr_1", 32'(bus_err), 32'd0);
        chk("to_idle",   32'(wreg_o),  32'd1);
        chk("to_noreq",  32'(bus.d_req), 32'd0);

        // flush in the second BUS cycle
        do_mem(LW_OP, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 3, 2, st, rq, sl, w, wdv, adv, stb);
        chk("fl_reqs",   32'(rq), 32'd4);
        chk("fl_data",   wdata_o, 32'hCAFE_F00D);
        chk("fl_wreg",   32'(wreg_o), 32'd0);
        gap();

        // flush in IDLE
        aluop_i = LW_OP; mem_addr_i = 32'h0000_4000; flush = 1'b1; #1;
        chk("fi_stall",  32'(stallreq), 32'd0);
        chk("fi_wreg",   32'(wreg_o),   32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fi_noreq",  32'(bus.d_req), 32'd0);
        gap();

        // async reset mid-BUS
        aluop_i = LW_OP; mem_addr_i = 32'h0000_5000; #1;
        @(posedge clk); #1;
        chk("ar_req",    32'(bus.d_req), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("ar_req0",   32'(bus.d_req), 32'd0);
        chk("ar_stall0", 32'(stallreq),  32'd0);
        chk("ar_wreg0",  32'(wreg_o),    32'd0);
        #2 rst = 1'b1;
        gap();
        chk("ar_idle",   32'(stallreq), 32'd0);
        chk("ar_noreq",  32'(bus.d_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
